// File: rtl/mrt_iter_ctrl_if.sv
// Handshake bundle between the minroot iteration sequencer and its host/engine.
// master drives job control and engine-done; slave is the sequencer itself.
interface mrt_iter_ctrl_if #(
    parameter int ITER_BITS  = 64,
    parameter int CHKPT_BITS = 16
);
    // job / engine inputs to the sequencer
    logic                  start_i;
    logic [ITER_BITS-1:0]  starting_iter_i;
    logic [ITER_BITS-1:0]  target_iter_i;
    logic [CHKPT_BITS-1:0] chkpt_interval_i;
    logic                  stop_i;
    logic                  eng_done_i;

    // sequencer outputs
    logic                  eng_start_o;
    logic                  eng_sel_feedback_o;
    logic [ITER_BITS-1:0]  eng_iter_o;
    logic [ITER_BITS-1:0]  iter_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  stopped_o;
    logic                  chkpt_valid_o;
    logic                  error_o;

    modport master (
        output start_i, starting_iter_i, target_iter_i, chkpt_interval_i,
               stop_i, eng_done_i,
        input  eng_start_o, eng_sel_feedback_o, eng_iter_o, iter_o, busy_o,
               done_o, stopped_o, chkpt_valid_o, error_o
    );

    modport slave (
        input  start_i, starting_iter_i, target_iter_i, chkpt_interval_i,
               stop_i, eng_done_i,
        output eng_start_o, eng_sel_feedback_o, eng_iter_o, iter_o, busy_o,
               done_o, stopped_o, chkpt_valid_o, error_o
    );
endinterface

// File: rtl/mrt_iter_ctrl.sv
// Iteration sequencer for the minroot engine: launches one engine run per
// iteration, steers the engine input mux (external load vs feedback), counts
// completed iterations, strobes checkpoints, honours graceful stop and flags a
// hung engine with a watchdog. All outputs are registered.
module mrt_iter_ctrl #(
    parameter int ITER_BITS    = 64,
    parameter int CHKPT_BITS   = 16,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    mrt_iter_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ITER_BITS-1:0]    ITER_ONE  = {{(ITER_BITS-1){1'b0}}, 1'b1};
    localparam logic [CHKPT_BITS-1:0]   CHKPT_ONE = {{(CHKPT_BITS-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_BITS-1:0] WDOG_ONE  = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
    // Watchdog value seen during the last permitted WAIT cycle; the count would
    // reach all-ones at the end of it.
    localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    state_t                  r_state;
    logic [ITER_BITS-1:0]    r_iter;
    logic [ITER_BITS-1:0]    r_target;
    logic [ITER_BITS-1:0]    r_eng_iter;
    logic [CHKPT_BITS-1:0]   r_interval;
    logic [CHKPT_BITS-1:0]   r_chkpt_cnt;
    logic [TIMEOUT_BITS-1:0] r_wdog;
    logic                    r_stop_pend;
    logic                    r_eng_start;
    logic                    r_sel_fb;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_stopped;
    logic                    r_chkpt_valid;
    logic                    r_error;

    logic [ITER_BITS-1:0]    w_iter_inc;
    logic [CHKPT_BITS-1:0]   w_chkpt_inc;
    logic                    w_chkpt_hit;
    logic                    w_job_empty;

    // Increment wraps naturally; completion is an equality compare.
    assign w_iter_inc  = r_iter + ITER_ONE;
    assign w_chkpt_inc = r_chkpt_cnt + CHKPT_ONE;
    assign w_chkpt_hit = (r_interval != '0) && (w_chkpt_inc == r_interval);
    assign w_job_empty = (bus.target_iter_i <= bus.starting_iter_i);

    // Sequencer FSM: state, counters and every output register in one place.
    // Outputs that describe the LAUNCH cycle (start pulse, mux select, engine
    // iteration) are set on the transition into LAUNCH so they coincide with
    // it. The mux select is 0 only for a launch coming straight from a job
    // start (the first iteration) and 1 for every launch coming from WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_iter        <= '0;
            r_target      <= '0;
            r_eng_iter    <= '0;
            r_interval    <= '0;
            r_chkpt_cnt   <= '0;
            r_wdog        <= '0;
            r_stop_pend   <= 1'b0;
            r_eng_start   <= 1'b0;
            r_sel_fb      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stopped     <= 1'b0;
            r_chkpt_valid <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_eng_start   <= 1'b0;
            r_done        <= 1'b0;
            r_chkpt_valid <= 1'b0;

            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (bus.start_i) begin
                        r_target    <= bus.target_iter_i;
                        r_interval  <= bus.chkpt_interval_i;
                        r_iter      <= bus.starting_iter_i;
                        r_stopped   <= 1'b0;
                        r_error     <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_chkpt_cnt <= '0;
                        r_busy      <= 1'b1;
                        if (w_job_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_LAUNCH;
                            r_eng_start <= 1'b1;
                            r_sel_fb    <= 1'b0;
                            r_eng_iter  <= bus.starting_iter_i;
                        end
                    end
                end

                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                    if (bus.stop_i) begin
                        r_stop_pend <= 1'b1;
                    end
                end

                S_WAIT: begin
                    r_wdog <= r_wdog + WDOG_ONE;
                    if (bus.stop_i) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (bus.eng_done_i) begin
                        r_iter <= w_iter_inc;
                        if (r_interval != '0) begin
                            if (w_chkpt_hit) begin
                                r_chkpt_valid <= 1'b1;
                                r_chkpt_cnt   <= '0;
                            end else begin
                                r_chkpt_cnt <= w_chkpt_inc;
                            end
                        end
                        if (w_iter_inc == r_target) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_stop_pend || bus.stop_i) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_stopped <= 1'b1;
                        end else begin
                            r_state     <= S_LAUNCH;
                            r_eng_start <= 1'b1;
                            r_sel_fb    <= 1'b1;
                            r_eng_iter  <= w_iter_inc;
                        end
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.eng_start_o        = r_eng_start;
    assign bus.eng_sel_feedback_o = r_sel_fb;
    assign bus.eng_iter_o         = r_eng_iter;
    assign bus.iter_o             = r_iter;
    assign bus.busy_o             = r_busy;
    assign bus.done_o             = r_done;
    assign bus.stopped_o          = r_stopped;
    assign bus.chkpt_valid_o      = r_chkpt_valid;
    assign bus.error_o            = r_error;
endmodule

// File: tb/tb_mrt_iter_ctrl.sv
// Bench for mrt_iter_ctrl: an engine model answers each eng_start_o after a
// programmable latency; expected launches, checkpoints and job completions are
// queued per scenario and checked by a negedge monitor as the DUT emits them.
module tb_mrt_iter_ctrl;
    localparam int IB = 64;
    localparam int CB = 16;
    localparam int TB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mrt_iter_ctrl_if #(.ITER_BITS(IB), .CHKPT_BITS(CB)) ifc ();

    mrt_iter_ctrl #(
        .ITER_BITS(IB),
        .CHKPT_BITS(CB),
        .TIMEOUT_BITS(TB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );

    int checks = 0;
    int errors = 0;
    int eng_lat = 5;   // 0 = engine never answers

    typedef struct packed { logic sel; logic [IB-1:0] iter; } launch_t;
    typedef struct packed { logic stopped; logic [IB-1:0] iter; } fin_t;

    launch_t        q_launch[$];
    fin_t           q_fin[$];
    logic [IB-1:0]  q_chk[$];

    // Engine model: raise eng_done_i for one cycle eng_lat cycles after a start.
    initial begin : engine
        int cnt;
        cnt = -1;
        ifc.eng_done_i = 1'b0;
        forever begin
            @(negedge clk);
            ifc.eng_done_i = 1'b0;
            if (ifc.eng_start_o && eng_lat > 0) begin
                cnt = eng_lat;
            end else if (ifc.eng_start_o) begin
                cnt = -1;
            end
            if (!ifc.eng_start_o && cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.eng_done_i = 1'b1;
                    cnt = -1;
                end
            end
        end
    end

    // Scoreboard monitor: every DUT event pops and compares its expectation.
    always @(negedge clk) begin : monitor
        launch_t el;
        fin_t ef;
        logic [IB-1:0] ec;
        if (ifc.eng_start_o) begin
            checks++;
            if (q_launch.size() == 0) begin
                errors++;
                $display("FAIL launch_unexpected got sel=%0b iter=%0d required no launch",
                         ifc.eng_sel_feedback_o, ifc.eng_iter_o);
            end else begin
                el = q_launch.pop_front();
                if ({ifc.eng_sel_feedback_o, ifc.eng_iter_o} !== el) begin
                    errors++;
                    $display("FAIL launch got sel=%0b iter=%0d required sel=%0b iter=%0d",
                             ifc.eng_sel_feedback_o, ifc.eng_iter_o, el.sel, el.iter);
                end else begin
                    $display("launch sel=%0b iter=%0d", el.sel, el.iter);
                end
            end
        end
        if (ifc.chkpt_valid_o) begin
            checks++;
            if (q_chk.size() == 0) begin
                errors++;
                $display("FAIL chkpt_unexpected got iter=%0d required no checkpoint", ifc.iter_o);
            end else begin
                ec = q_chk.pop_front();
                if (ifc.iter_o !== ec) begin
                    errors++;
                    $display("FAIL chkpt got iter=%0d required iter=%0d", ifc.iter_o, ec);
                end else begin
                    $display("chkpt iter=%0d", ec);
                end
            end
        end
        if (ifc.done_o) begin
            checks++;
            if (q_fin.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got iter=%0d stopped=%0b required no done",
                         ifc.iter_o, ifc.stopped_o);
            end else begin
                ef = q_fin.pop_front();
                if ({ifc.stopped_o, ifc.iter_o} !== ef) begin
                    errors++;
                    $display("FAIL done got iter=%0d stopped=%0b required iter=%0d stopped=%0b",
                             ifc.iter_o, ifc.stopped_o, ef.iter, ef.stopped);
                end else begin
                    $display("done iter=%0d stopped=%0b", ef.iter, ef.stopped);
                end
            end
        end
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic drive_job(input logic [IB-1:0] s, input logic [IB-1:0] t,
                             input logic [CB-1:0] iv);
        @(negedge clk);
        ifc.starting_iter_i  = s;
        ifc.target_iter_i    = t;
        ifc.chkpt_interval_i = iv;
        ifc.start_i          = 1'b1;
        @(posedge clk);
        #1 ifc.start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        ifc.stop_i = 1'b1;
        @(posedge clk);
        #1 ifc.stop_i = 1'b0;
    endtask

    task automatic wait_launches(input string name, input int n, input int limit);
        int seen;
        seen = 0;
        for (int i = 0; i < limit && seen < n; i++) begin
            @(negedge clk);
            if (ifc.eng_start_o) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s_launch_timeout got %0d launches required %0d", name, seen, n);
        end
    endtask

    task automatic wait_job(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (ifc.done_o) seen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got done_o=0 required done within %0d cycles", name, limit);
        end
        checks++;
        if (q_launch.size() + q_fin.size() + q_chk.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got launch=%0d chk=%0d done=%0d outstanding required 0",
                     name, q_launch.size(), q_chk.size(), q_fin.size());
        end
        q_launch.delete();
        q_fin.delete();
        q_chk.delete();
    endtask

    task automatic test_reset();
        ifc.start_i          = 1'b0;
        ifc.stop_i           = 1'b0;
        ifc.starting_iter_i  = '0;
        ifc.target_iter_i    = '0;
        ifc.chkpt_interval_i = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.eng_start_o, ifc.eng_sel_feedback_o, ifc.eng_iter_o, ifc.iter_o, ifc.busy_o,
             ifc.done_o, ifc.stopped_o, ifc.chkpt_valid_o, ifc.error_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got iter=%0d busy=%0b err=%0b required all zero",
                     ifc.iter_o, ifc.busy_o, ifc.error_o);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.busy_o !== 1'b0 || ifc.eng_start_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b eng_start=%0b required 0 0",
                     ifc.busy_o, ifc.eng_start_o);
        end
    endtask

    task automatic test_basic();
        eng_lat = 5;
        q_launch.push_back({1'b0, 64'd0});
        q_launch.push_back({1'b1, 64'd1});
        q_launch.push_back({1'b1, 64'd2});
        q_fin.push_back({1'b0, 64'd3});
        drive_job(64'd0, 64'd3, 16'd0);
        wait_job("basic", 100);
        checks++;
        if (ifc.iter_o !== 64'd3 || ifc.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_final got iter=%0d busy=%0b required 3 0", ifc.iter_o, ifc.busy_o);
        end
    endtask

    task automatic test_zero_len();
        q_fin.push_back({1'b0, 64'd10});
        drive_job(64'd10, 64'd10, 16'd0);
        wait_job("zero_len", 3);
        checks++;
        if (ifc.iter_o !== 64'd10) begin
            errors++;
            $display("FAIL zero_len_iter got %0d required 10", ifc.iter_o);
        end
    endtask

    task automatic test_chkpt();
        eng_lat = 2;
        for (int i = 0; i < 8; i++) begin
            q_launch.push_back({(i != 0), 64'(i)});
        end
        q_chk.push_back(64'd3);
        q_chk.push_back(64'd6);
        q_fin.push_back({1'b0, 64'd8});
        drive_job(64'd0, 64'd8, 16'd3);
        wait_job("chkpt", 200);
    endtask

    task automatic test_stop();
        eng_lat = 5;
        q_launch.push_back({1'b0, 64'd0});
        q_launch.push_back({1'b1, 64'd1});
        q_fin.push_back({1'b1, 64'd2});
        drive_job(64'd0, 64'd100, 16'd0);
        wait_launches("stop", 2, 50);
        pulse_stop();
        wait_job("stop", 50);
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.stopped_o !== 1'b1 || ifc.iter_o !== 64'd2) begin
            errors++;
            $display("FAIL stop_sticky got stopped=%0b iter=%0d required 1 2",
                     ifc.stopped_o, ifc.iter_o);
        end
        // Stop during the final iteration: completion wins over stop.
        q_launch.push_back({1'b0, 64'd97});
        q_launch.push_back({1'b1, 64'd98});
        q_launch.push_back({1'b1, 64'd99});
        q_fin.push_back({1'b0, 64'd100});
        drive_job(64'd97, 64'd100, 16'd0);
        wait_launches("stop_last", 3, 60);
        pulse_stop();
        wait_job("stop_last", 50);
        checks++;
        if (ifc.stopped_o !== 1'b0 || ifc.iter_o !== 64'd100) begin
            errors++;
            $display("FAIL stop_last_final got stopped=%0b iter=%0d required 0 100",
                     ifc.stopped_o, ifc.iter_o);
        end
    endtask

    task automatic test_watchdog();
        eng_lat = 0;
        q_launch.push_back({1'b0, 64'd5});
        drive_job(64'd5, 64'd9, 16'd0);
        wait_launches("wdog", 1, 10);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                checks++;
                if (ifc.error_o !== 1'b0 || ifc.busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wdog_early got error=%0b busy=%0b required 0 1",
                             ifc.error_o, ifc.busy_o);
                end
            end
            if (k == 16) begin
                checks++;
                if (ifc.error_o !== 1'b1 || ifc.busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wdog_fire got error=%0b busy=%0b required 1 0",
                             ifc.error_o, ifc.busy_o);
                end
            end
        end
        // Restart from ERROR; eng_done arrives on the last watchdog cycle and wins.
        eng_lat = 15;
        q_launch.push_back({1'b0, 64'd0});
        q_fin.push_back({1'b0, 64'd1});
        drive_job(64'd0, 64'd1, 16'd0);
        wait_job("wdog_restart", 40);
        checks++;
        if (ifc.error_o !== 1'b0 || ifc.iter_o !== 64'd1) begin
            errors++;
            $display("FAIL wdog_restart_final got error=%0b iter=%0d required 0 1",
                     ifc.error_o, ifc.iter_o);
        end
    endtask

    task automatic test_busy_start();
        eng_lat = 2;
        for (int i = 0; i < 4; i++) begin
            q_launch.push_back({(i != 0), 64'(i)});
        end
        q_fin.push_back({1'b0, 64'd4});
        drive_job(64'd0, 64'd4, 16'd0);
        wait_launches("busy_start", 1, 10);
        drive_job(64'd50, 64'd51, 16'd0);
        wait_job("busy_start", 60);
        checks++;
        if (ifc.iter_o !== 64'd4) begin
            errors++;
            $display("FAIL busy_start_iter got %0d required 4", ifc.iter_o);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        eng_lat = 6;
        q_launch.push_back({1'b0, 64'd0});
        drive_job(64'd0, 64'd5, 16'd0);
        wait_launches("reset_mid", 1, 10);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ifc.eng_start_o, ifc.eng_sel_feedback_o, ifc.eng_iter_o, ifc.iter_o, ifc.busy_o,
             ifc.done_o, ifc.stopped_o, ifc.chkpt_valid_o, ifc.error_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got iter=%0d busy=%0b required all zero",
                     ifc.iter_o, ifc.busy_o);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.done_o || ifc.busy_o || ifc.eng_start_o || ifc.iter_o != '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_quiet got activity after reset required none");
        end
        checks++;
        if (q_launch.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pending got %0d launches outstanding required 0",
                     q_launch.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_zero_len();
        test_chkpt();
        test_stop();
        test_watchdog();
        test_busy_start();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
